exception_cp0: RTL and testbench

Precise-exception unit and CP0 register subset sitting at the MEM stage. It receives the load/store address-error flags produced by the MEM-stage alignment check together with the decode/execute exception flags and external interrupts. It arbitrates a single exception per committing instruction, updates BadVAddr/EPC/Status/Cause, and drives the pipeline flush and redirect PC. It also implements the Count/Compare timer and the mtc0/mfc0 access port.

---
 rtl/cp0_defs.sv | 52 +++++
 rtl/exc_arbiter.sv | 56 +++++
 rtl/exception_cp0.sv | 202 ++++++++++++++++++++
 tb/tb_exception_cp0.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_defs.sv
// Purpose: shared CP0 register numbers, exception codes, field positions and arbiter types.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cp0_defs;

    // CP0 register numbers implemented by this unit
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    // Cause.ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    // Status field positions
    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int ST_IM_LO  = 8;
    localparam int ST_BEV    = 22;

    // Cause field positions
    localparam int CA_CODE_LO = 2;
    localparam int CA_IP_LO   = 8;
    localparam int CA_TI      = 30;
    localparam int CA_BD      = 31;

    // Which value, if any, is captured into BadVAddr
    typedef enum logic [1:0] {
        BADV_KEEP = 2'd0,
        BADV_PC   = 2'd1,
        BADV_ADDR = 2'd2
    } badv_sel_e;

    // Arbiter decision for the instruction currently in MEM
    typedef struct packed {
        logic       take;      // an exception is raised
        logic [4:0] code;      // ExcCode of the winning exception
        logic       is_eret;   // eret wins (no exception present)
        badv_sel_e  badv_sel;  // BadVAddr source
    } exc_req_t;

endpackage

// File: rtl/exc_arbiter.sv
// Purpose: picks the single highest-priority exception (or eret) for the MEM-stage instruction.
// Latency: combinational, 0 cycles.
// Backpressure: none; commit gating is applied by the caller.
// Ports: int_pending + per-cause flags in, exc_req_t decision out.
module exc_arbiter
    import cp0_defs::*;
(
    input  logic     int_pending,
    input  logic     fetch_adel,
    input  logic     ri,
    input  logic     ov,
    input  logic     sys,
    input  logic     bp,
    input  logic     data_adel,
    input  logic     data_ades,
    input  logic     eret,
    output exc_req_t req
);

    always_comb begin
        req          = '0;
        req.badv_sel = BADV_KEEP;
        if (int_pending) begin
            req.take = 1'b1;
            req.code = EXC_INT;
        end else if (fetch_adel) begin
            req.take     = 1'b1;
            req.code     = EXC_ADEL;
            req.badv_sel = BADV_PC;
        end else if (ri) begin
            req.take = 1'b1;
            req.code = EXC_RI;
        end else if (ov) begin
            req.take = 1'b1;
            req.code = EXC_OV;
        end else if (sys) begin
            req.take = 1'b1;
            req.code = EXC_SYS;
        end else if (bp) begin
            req.take = 1'b1;
            req.code = EXC_BP;
        end else if (data_adel) begin
            req.take     = 1'b1;
            req.code     = EXC_ADEL;
            req.badv_sel = BADV_ADDR;
        end else if (data_ades) begin
            req.take     = 1'b1;
            req.code     = EXC_ADES;
            req.badv_sel = BADV_ADDR;
        end else if (eret) begin
            // eret is not an exception: it only redirects and drops EXL
            req.is_eret = 1'b1;
        end
    end

endmodule

// File: rtl/exception_cp0.sv
// Purpose: MEM-stage precise exception unit + CP0 subset (BadVAddr/Count/Compare/Status/Cause/EPC).
// Latency: flush_exc/exc_pc combinational in the commit cycle; CP0 state visible 1 cycle later.
// Backpressure: stallM or ~validM blocks exceptions and mtc0; the timer keeps running.
// Ports: clk/resetn; MEM-stage pc/addr/flags; ext_int[5:0]; mtc0/mfc0 port; flush_exc/exc_pc out.
module exception_cp0
    import cp0_defs::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        validM,
    input  logic        stallM,
    input  logic [31:0] pcM,
    input  logic        is_in_delayslotM,
    input  logic [31:0] addrM,
    input  logic        addr_error_lw,
    input  logic        addr_error_sw,
    input  logic        riM,
    input  logic        overflowM,
    input  logic        syscallM,
    input  logic        breakM,
    input  logic        eretM,
    input  logic [5:0]  ext_int,
    input  logic        mtc0M,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    output logic        flush_exc,
    output logic [31:0] exc_pc
);

    // Status fields (BEV is hard-wired to 1, everything else reads 0)
    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;

    // Cause fields
    logic        bd_q, bd_d;
    logic        ti_q, ti_d;
    logic [7:0]  ip_q, ip_d;
    logic [4:0]  exc_code_q, exc_code_d;

    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        tick_q, tick_d;

    logic        commit;
    logic        int_pending;
    logic        fire_exc;
    logic        fire_eret;
    logic        wr_en;
    logic [31:0] status_val;
    logic [31:0] cause_val;
    exc_req_t    req;

    assign commit      = validM & ~stallM & resetn;
    assign int_pending = ie_q & ~exl_q & (|(ip_q & im_q));

    exc_arbiter u_arb (
        .int_pending (int_pending),
        .fetch_adel  (pcM[1:0] != 2'b00),
        .ri          (riM),
        .ov          (overflowM),
        .sys         (syscallM),
        .bp          (breakM),
        .data_adel   (addr_error_lw),
        .data_ades   (addr_error_sw),
        .eret        (eretM),
        .req         (req)
    );

    assign fire_exc  = commit & req.take;
    assign fire_eret = commit & req.is_eret;
    assign flush_exc = fire_exc | fire_eret;
    assign exc_pc    = fire_eret ? epc_q : EXC_VECTOR;

    // A redirecting instruction never commits, so its mtc0 must not either
    assign wr_en = commit & mtc0M & ~flush_exc;

    always_comb begin
        status_val                        = '0;
        status_val[ST_BEV]                = 1'b1;
        status_val[ST_IM_LO +: 8]         = im_q;
        status_val[ST_EXL]                = exl_q;
        status_val[ST_IE]                 = ie_q;
    end

    always_comb begin
        cause_val                         = '0;
        cause_val[CA_BD]                  = bd_q;
        cause_val[CA_TI]                  = ti_q;
        cause_val[CA_IP_LO +: 8]          = ip_q;
        cause_val[CA_CODE_LO +: 5]        = exc_code_q;
    end

    // Read port: registered state only, no bypass of this cycle's write
    always_comb begin
        cp0_rdata = '0;
        case (cp0_raddr)
            CP0_BADVADDR: cp0_rdata = badvaddr_q;
            CP0_COUNT:    cp0_rdata = count_q;
            CP0_COMPARE:  cp0_rdata = compare_q;
            CP0_STATUS:   cp0_rdata = status_val;
            CP0_CAUSE:    cp0_rdata = cause_val;
            CP0_EPC:      cp0_rdata = epc_q;
            default:      cp0_rdata = '0;
        endcase
    end

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ti_d       = ti_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        compare_d  = compare_q;

        // Timer: Count advances every other cycle
        tick_d  = ~tick_q;
        count_d = count_q + {31'd0, tick_q};

        // IP[7] merges the timer with ext_int[5]; IP[1:0] are software bits
        ip_d = {ext_int[5] | ti_q, ext_int[4:0], ip_q[1:0]};

        if (wr_en) begin
            case (cp0_waddr)
                CP0_COUNT:   count_d   = cp0_wdata;
                CP0_COMPARE: compare_d = cp0_wdata;
                CP0_STATUS: begin
                    im_d  = cp0_wdata[ST_IM_LO +: 8];
                    exl_d = cp0_wdata[ST_EXL];
                    ie_d  = cp0_wdata[ST_IE];
                end
                CP0_CAUSE:   ip_d[1:0] = cp0_wdata[CA_IP_LO +: 2];
                CP0_EPC:     epc_d     = cp0_wdata;
                default: ;
            endcase
        end

        // Writing Compare acknowledges the timer even if the counts match
        if (wr_en && (cp0_waddr == CP0_COMPARE)) begin
            ti_d = 1'b0;
        end else if (count_d == compare_q) begin
            ti_d = 1'b1;
        end

        if (fire_exc) begin
            exl_d      = 1'b1;
            exc_code_d = req.code;
            // A nested exception must not clobber the original return point
            if (!exl_q) begin
                bd_d  = is_in_delayslotM;
                epc_d = is_in_delayslotM ? (pcM - 32'd4) : pcM;
            end
            case (req.badv_sel)
                BADV_PC:   badvaddr_d = pcM;
                BADV_ADDR: badvaddr_d = addrM;
                default:   badvaddr_d = badvaddr_q;
            endcase
        end else if (fire_eret) begin
            exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_q       <= '0;
            exc_code_q <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            tick_q     <= 1'b0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            tick_q     <= tick_d;
        end
    end

endmodule

// File: tb/tb_exception_cp0.sv
module tb_exception_cp0;

    localparam int SEL_FLUSH = 32;
    localparam int SEL_EXCPC = 33;
    localparam logic [31:0] VEC = 32'hBFC0_0380;
    localparam logic [31:0] ALL = 32'hFFFF_FFFF;
    localparam logic [31:0] M_CODE = 32'h0000_007C;
    localparam logic [31:0] M_EXL  = 32'h0000_0002;

    logic        clk = 1'b0;
    logic        resetn;
    logic        validM, stallM, is_in_delayslotM;
    logic [31:0] pcM, addrM;
    logic        addr_error_lw, addr_error_sw;
    logic        riM, overflowM, syscallM, breakM, eretM;
    logic [5:0]  ext_int;
    logic        mtc0M;
    logic [4:0]  cp0_waddr, cp0_raddr;
    logic [31:0] cp0_wdata, cp0_rdata;
    logic        flush_exc;
    logic [31:0] exc_pc;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] mask;
        logic [31:0] val;
    } exp_t;

    exp_t comb_q[$];
    exp_t reg_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    exception_cp0 dut (
        .clk              (clk),
        .resetn           (resetn),
        .validM           (validM),
        .stallM           (stallM),
        .pcM              (pcM),
        .is_in_delayslotM (is_in_delayslotM),
        .addrM            (addrM),
        .addr_error_lw    (addr_error_lw),
        .addr_error_sw    (addr_error_sw),
        .riM              (riM),
        .overflowM        (overflowM),
        .syscallM         (syscallM),
        .breakM           (breakM),
        .eretM            (eretM),
        .ext_int          (ext_int),
        .mtc0M            (mtc0M),
        .cp0_waddr        (cp0_waddr),
        .cp0_wdata        (cp0_wdata),
        .cp0_raddr        (cp0_raddr),
        .cp0_rdata        (cp0_rdata),
        .flush_exc        (flush_exc),
        .exc_pc           (exc_pc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic exp_comb(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.sel = sel; e.mask = ALL; e.val = v;
        comb_q.push_back(e);
    endtask

    task automatic exp_reg(input string tag, input int sel, input logic [31:0] m, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.sel = sel; e.mask = m; e.val = v;
        reg_q.push_back(e);
    endtask

    task automatic drain_comb();
        exp_t e;
        logic [31:0] obs;
        while (comb_q.size() > 0) begin
            e = comb_q.pop_front();
            obs = (e.sel == SEL_FLUSH) ? {31'd0, flush_exc} : exc_pc;
            check(e.tag, obs & e.mask, e.val);
        end
    endtask

    task automatic drain_reg();
        exp_t e;
        while (reg_q.size() > 0) begin
            e = reg_q.pop_front();
            cp0_raddr = e.sel[4:0];
            #1;
            check(e.tag, cp0_rdata & e.mask, e.val);
        end
    endtask

    task automatic set_idle();
        validM = 0; stallM = 0; is_in_delayslotM = 0;
        pcM = 32'hBFC0_0000; addrM = 0;
        addr_error_lw = 0; addr_error_sw = 0;
        riM = 0; overflowM = 0; syscallM = 0; breakM = 0; eretM = 0;
        ext_int = 0; mtc0M = 0; cp0_waddr = 0; cp0_wdata = 0;
    endtask

    // Inputs are already driven at posedge+1: check comb outputs, clock, check registers
    task automatic cycle();
        #2;
        drain_comb();
        @(posedge clk);
        #1;
        set_idle();
        drain_reg();
    endtask

    task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
        validM = 1; pcM = 32'hBFC0_0F00; mtc0M = 1; cp0_waddr = r; cp0_wdata = d;
        exp_comb("mtc0_noflush", SEL_FLUSH, 0);
        cycle();
    endtask

    task automatic clear_exl();
        mtc0(5'd12, 32'h0);
        exp_reg("clr_exl", 12, M_EXL, 0);
        drain_reg();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        set_idle();
        resetn = 0;
        cp0_raddr = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset: flush blocked, registers at reset values
        validM = 1; syscallM = 1; pcM = 32'hBFC0_0010;
        exp_comb("rst_flush", SEL_FLUSH, 0);
        exp_reg("rst_status", 12, ALL, 32'h0040_0000);
        exp_reg("rst_cause", 13, ALL, 0);
        exp_reg("rst_epc", 14, ALL, 0);
        exp_reg("rst_badv", 8, ALL, 0);
        exp_reg("rst_count", 9, ALL, 0);
        exp_reg("rst_compare", 11, ALL, 0);
        cycle();
        resetn = 1;

        // External interrupt lines land in Cause.IP
        ext_int = 6'b000100;
        exp_reg("cause_ip_ext", 13, 32'h0000_FC00, 32'h0000_1000);
        cycle();

        // Data AdEL
        validM = 1; pcM = 32'hBFC0_0100; addrM = 32'h8000_0002; addr_error_lw = 1;
        exp_comb("adel_flush", SEL_FLUSH, 1);
        exp_comb("adel_pc", SEL_EXCPC, VEC);
        exp_reg("adel_epc", 14, ALL, 32'hBFC0_0100);
        exp_reg("adel_badv", 8, ALL, 32'h8000_0002);
        exp_reg("adel_code", 13, M_CODE, 32'h10);
        exp_reg("adel_exl", 12, M_EXL, 2);
        cycle();
        clear_exl();

        // AdES in a delay slot
        validM = 1; pcM = 32'hBFC0_0204; is_in_delayslotM = 1;
        addrM = 32'h1000_0001; addr_error_sw = 1;
        exp_comb("ades_flush", SEL_FLUSH, 1);
        exp_reg("ades_epc", 14, ALL, 32'hBFC0_0200);
        exp_reg("ades_bd_code", 13, 32'h8000_007C, 32'h8000_0014);
        exp_reg("ades_badv", 8, ALL, 32'h1000_0001);
        cycle();
        clear_exl();

        // RI beats data AdEL, BadVAddr untouched
        validM = 1; pcM = 32'hBFC0_0208; riM = 1; addr_error_lw = 1; addrM = 32'h2000_0003;
        exp_comb("ri_flush", SEL_FLUSH, 1);
        exp_reg("ri_code", 13, M_CODE, 32'h28);
        exp_reg("ri_badv", 8, ALL, 32'h1000_0001);
        exp_reg("ri_epc", 14, ALL, 32'hBFC0_0208);
        cycle();
        clear_exl();

        // Same flags while stalled: nothing happens
        validM = 1; stallM = 1; pcM = 32'hBFC0_020C; riM = 1; addr_error_lw = 1; addrM = 32'h2000_0003;
        exp_comb("stall_flush", SEL_FLUSH, 0);
        exp_reg("stall_exl", 12, M_EXL, 0);
        exp_reg("stall_epc", 14, ALL, 32'hBFC0_0208);
        exp_reg("stall_code", 13, M_CODE, 32'h28);
        cycle();

        // Ov, then a nested Sys with EXL already set
        validM = 1; pcM = 32'hBFC0_0310; overflowM = 1;
        exp_comb("ov_flush", SEL_FLUSH, 1);
        exp_reg("ov_code", 13, M_CODE, 32'h30);
        exp_reg("ov_epc", 14, ALL, 32'hBFC0_0310);
        cycle();
        validM = 1; pcM = 32'hBFC0_0404; is_in_delayslotM = 1; syscallM = 1;
        exp_comb("nest_pc", SEL_EXCPC, VEC);
        exp_reg("nest_code_bd", 13, 32'h8000_007C, 32'h20);
        exp_reg("nest_epc", 14, ALL, 32'hBFC0_0310);
        cycle();

        // eret returns to EPC and drops EXL
        mtc0(5'd14, 32'hBFC0_0300);
        exp_reg("mtc0_epc", 14, ALL, 32'hBFC0_0300);
        drain_reg();
        validM = 1; pcM = 32'hBFC0_0F04; eretM = 1;
        exp_comb("eret_flush", SEL_FLUSH, 1);
        exp_comb("eret_pc", SEL_EXCPC, 32'hBFC0_0300);
        exp_reg("eret_exl", 12, M_EXL, 0);
        cycle();

        // Fetch AdEL beats RI and data AdEL
        validM = 1; pcM = 32'hBFC0_0102; riM = 1; addr_error_lw = 1; addrM = 32'h3000_0000;
        exp_comb("fadel_pc", SEL_EXCPC, VEC);
        exp_reg("fadel_code", 13, M_CODE, 32'h10);
        exp_reg("fadel_badv", 8, ALL, 32'hBFC0_0102);
        cycle();
        clear_exl();

        // Syscall beats eret: vector, not EPC
        validM = 1; pcM = 32'hBFC0_0600; eretM = 1; syscallM = 1;
        exp_comb("sys_eret_pc", SEL_EXCPC, VEC);
        exp_reg("sys_eret_epc", 14, ALL, 32'hBFC0_0600);
        exp_reg("sys_eret_exl", 12, M_EXL, 2);
        cycle();
        clear_exl();

        // mtc0 EPC suppressed by a same-cycle syscall
        validM = 1; pcM = 32'hBFC0_0400; syscallM = 1;
        mtc0M = 1; cp0_waddr = 5'd14; cp0_wdata = 32'h1234_5678;
        exp_comb("supp_flush", SEL_FLUSH, 1);
        exp_reg("supp_epc", 14, ALL, 32'hBFC0_0400);
        exp_reg("supp_code", 13, M_CODE, 32'h20);
        cycle();
        clear_exl();

        // Writes to read-only / unimplemented registers are ignored
        mtc0(5'd8, 32'hFFFF_FFFF);
        mtc0(5'd0, 32'hFFFF_FFFF);
        exp_reg("ro_badv", 8, ALL, 32'hBFC0_0102);
        exp_reg("unimpl_r0", 0, ALL, 0);
        drain_reg();

        // Timer interrupt
        mtc0(5'd11, 32'd5);
        exp_reg("cmp_clr_ti", 13, 32'h4000_0000, 0);
        drain_reg();
        mtc0(5'd9, 32'd0);
        mtc0(5'd12, 32'h0000_8001);
        exp_reg("tmr_status", 12, ALL, 32'h0040_8001);
        drain_reg();
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            cp0_raddr = 5'd13;
            #1;
            if (cp0_rdata[30]) seen = 1;
        end
        check("ti_set", {31'd0, seen}, 1);
        exp_reg("ti_count", 9, ALL, 32'd5);
        drain_reg();
        repeat (3) @(posedge clk);
        #1;
        exp_comb("bubble_noflush", SEL_FLUSH, 0);
        exp_reg("bubble_code", 13, M_CODE, 32'h20);
        cycle();
        validM = 1; pcM = 32'hBFC0_0500;
        exp_comb("int_flush", SEL_FLUSH, 1);
        exp_comb("int_pc", SEL_EXCPC, VEC);
        exp_reg("int_code", 13, M_CODE, 0);
        exp_reg("int_epc", 14, ALL, 32'hBFC0_0500);
        exp_reg("int_exl", 12, M_EXL, 2);
        cycle();
        mtc0(5'd11, 32'd100);
        exp_reg("ti_ack", 13, 32'h4000_0000, 0);
        drain_reg();

        // Reset mid-operation drops the flush and restores state
        resetn = 0; validM = 1; syscallM = 1; pcM = 32'hBFC0_0700;
        exp_comb("mid_rst_flush", SEL_FLUSH, 0);
        exp_reg("mid_rst_status", 12, ALL, 32'h0040_0000);
        exp_reg("mid_rst_epc", 14, ALL, 0);
        exp_reg("mid_rst_count", 9, ALL, 0);
        exp_reg("mid_rst_compare", 11, ALL, 0);
        cycle();
        resetn = 1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
